// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data.
// Data wins by default; a burst limit keeps fetch from starving.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DBURST = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic              err,
    output logic              err_sticky
);

    localparam int DB_W = $clog2(MAX_DBURST + 1);
    localparam int WC_W = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;

    logic [1:0]      state;
    logic [DB_W-1:0] dburst;
    logic [WC_W-1:0] wait_cnt;

    logic idle;
    logic busy_if;
    logic busy_d;
    logic busy;
    logic db_room;
    logic gnt_d;
    logic gnt_f;
    logic tmo_hit;
    logic timeout;
    logic done;
    logic rd_ok;

    assign idle    = (state == IDLE);
    assign busy_if = (state == BUSY_IF);
    assign busy_d  = (state == BUSY_D);
    assign busy    = busy_if | busy_d;
    assign db_room = (dburst < DB_W'(MAX_DBURST));

    // Data has priority unless it has already won MAX_DBURST times in a row
    assign gnt_d = idle & d_req & (~if_req | db_room);
    assign gnt_f = idle & if_req & ~gnt_d;

    assign tmo_hit = (wait_cnt == WC_W'(TIMEOUT - 1));
    assign timeout = busy & tmo_hit & ~mem_ack;
    assign done    = busy & (mem_ack | tmo_hit);
    assign rd_ok   = mem_ack & ~mem_we;

    assign if_ready = busy_if & done;
    assign d_ready  = busy_d & done;
    assign if_rdata = (busy_if & rd_ok) ? mem_rdata : '0;
    assign d_rdata  = (busy_d & rd_ok) ? mem_rdata : '0;

    assign stall_f = if_req & ~if_ready;
    assign stall_m = d_req & ~d_ready;
    assign err     = timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (1'b1)
                gnt_d: begin
                    state     <= BUSY_D;
                    mem_req   <= 1'b1;
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end
                gnt_f: begin
                    state     <= BUSY_IF;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end
                done: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: begin
                    if (!busy) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dburst <= '0;
        end else if (!if_req || gnt_f) begin
            dburst <= '0;
        end else if (gnt_d && db_room) begin
            dburst <= dburst + DB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (gnt_d || gnt_f || done) begin
            wait_cnt <= '0;
        end else if (busy) begin
            wait_cnt <= wait_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
        end else if (timeout) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written
// sequences for arbitration, starvation, timeout and reset.
module tb_mem_port_arbiter;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_f;
    logic        stall_m;
    logic        err;
    logic        err_sticky;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DBURST(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .stall_f(stall_f), .stall_m(stall_m),
        .err(err), .err_sticky(err_sticky)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        if_req  = ~v.is_d;
        if_addr = v.addr;
        d_req   = v.is_d;
        d_we    = v.we;
        d_addr  = v.addr;
        d_wdata = v.wdata;
        @(negedge clk);
        chk({p, " req_cycle mem_req"}, mem_req, 0);
        chk({p, " stall"}, v.is_d ? stall_m : stall_f, 1);
        @(posedge clk); #1;
        for (int i = 1; i < v.delay; i++) begin
            @(negedge clk);
            chk({p, " wait ready"}, if_ready | d_ready, 0);
            chk({p, " wait mem_req"}, mem_req, 1);
            @(posedge clk); #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = v.mrdata;
        @(negedge clk);
        chk({p, " mem_addr"}, mem_addr, v.addr);
        chk({p, " mem_we"}, mem_we, v.is_d ? v.we : 1'b0);
        chk({p, " mem_wdata"}, mem_wdata, v.is_d ? v.wdata : 32'h0);
        chk({p, " own ready"}, v.is_d ? d_ready : if_ready, 1);
        chk({p, " other ready"}, v.is_d ? if_ready : d_ready, 0);
        chk({p, " own rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        chk({p, " other rdata"}, v.is_d ? if_rdata : d_rdata, 0);
        chk({p, " stall off"}, v.is_d ? stall_m : stall_f, 0);
        chk({p, " err"}, err, 0);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if_req    = 1'b0;
        d_req     = 1'b0;
        @(negedge clk);
        chk({p, " mem_req clear"}, mem_req, 0);
        chk({p, " mem_we clear"}, mem_we, 0);
    endtask

    task automatic busy_wait(input string p);
        for (int c = 1; c < TMO; c++) begin
            @(negedge clk);
            chk({p, " busy ready"}, if_ready, 0);
            chk({p, " busy err"}, err, 0);
            chk({p, " busy mem_req"}, mem_req, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] seq_addr[6];

        vecs[0] = '{0, 0, 32'h0000_0040, 32'h0, 1, 32'h8C22_0004, 32'h8C22_0004};
        vecs[1] = '{0, 0, 32'h0000_0044, 32'h0, 3, 32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{1, 0, 32'h0000_0200, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[3] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h5555_5555, 32'h0};
        vecs[4] = '{1, 0, 32'hFFFF_FFFC, 32'h0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{0, 0, 32'h0000_0000, 32'h0, 2, 32'hA5A5_A5A5, 32'hA5A5_A5A5};

        rst = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ack = 0;

        // reset values, stalls follow inputs
        #2;
        if_req = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_1111;
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst err_sticky", err_sticky, 0);
        chk("rst err", err, 0);
        chk("rst if_ready", if_ready, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst stall_f", stall_f, 1);
        chk("rst stall_m", stall_m, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst hold mem_req", mem_req, 0);
        if_req = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        rst = 1'b1;

        // ack while idle is ignored
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("idle_ack if_ready", if_ready, 0);
        chk("idle_ack d_ready", d_ready, 0);
        chk("idle_ack d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        chk("idle_ack mem_req", mem_req, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // simultaneous requests: data first, fetch right after d_ready
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h80;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("sim mem_we", mem_we, 1);
        chk("sim mem_addr", mem_addr, 32'h100);
        chk("sim mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sim d_ready", d_ready, 1);
        chk("sim d_rdata", d_rdata, 0);
        chk("sim if_ready", if_ready, 0);
        chk("sim stall_f", stall_f, 1);
        @(posedge clk); #1;
        mem_ack = 0; d_req = 0; d_we = 0;
        @(negedge clk);
        chk("sim gap mem_req", mem_req, 0);
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        chk("sim f mem_addr", mem_addr, 32'h80);
        chk("sim f mem_we", mem_we, 0);
        chk("sim f mem_wdata", mem_wdata, 0);
        chk("sim f if_ready", if_ready, 1);
        chk("sim f if_rdata", if_rdata, 32'hAAAA_5555);
        @(posedge clk); #1;
        mem_ack = 0; if_req = 0; mem_rdata = 0;

        // starvation guard: D D D D F D
        seq_addr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000,
                     32'h1000, 32'h2000};
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h1000;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        for (int g = 0; g < 6; g++) begin
            @(posedge clk); #1;
            mem_ack = 1; mem_rdata = 32'h3000 + g;
            @(negedge clk);
            chk($sformatf("burst g%0d mem_addr", g), mem_addr, seq_addr[g]);
            chk($sformatf("burst g%0d d_ready", g), d_ready,
                (seq_addr[g] == 32'h2000) ? 32'd1 : 32'd0);
            chk($sformatf("burst g%0d if_ready", g), if_ready,
                (seq_addr[g] == 32'h1000) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            mem_ack = 0;
        end
        if_req = 0; d_req = 0; mem_rdata = 0;

        // ack collides with the last timeout cycle: ack wins
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h500;
        @(posedge clk); #1;
        busy_wait("coll");
        mem_ack = 1; mem_rdata = 32'h0BAD_C0DE;
        @(negedge clk);
        chk("coll if_ready", if_ready, 1);
        chk("coll if_rdata", if_rdata, 32'h0BAD_C0DE);
        chk("coll err", err, 0);
        @(posedge clk); #1;
        mem_ack = 0; if_req = 0; mem_rdata = 0;
        @(negedge clk);
        chk("coll mem_req", mem_req, 0);
        chk("coll err_sticky", err_sticky, 0);

        // timeout abort
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h300; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        busy_wait("tmo");
        @(negedge clk);
        chk("tmo if_ready", if_ready, 1);
        chk("tmo if_rdata", if_rdata, 0);
        chk("tmo err", err, 1);
        chk("tmo err_sticky pre", err_sticky, 0);
        @(posedge clk); #1;
        if_req = 0; mem_rdata = 0;
        @(negedge clk);
        chk("tmo mem_req", mem_req, 0);
        chk("tmo err after", err, 0);
        chk("tmo err_sticky", err_sticky, 1);
        @(posedge clk);
        @(negedge clk);
        chk("tmo err_sticky hold", err_sticky, 1);

        // reset mid-transaction, then re-grant
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 32'h400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid busy mem_req", mem_req, 1);
        #1 rst = 1'b0;
        #1;
        chk("rstmid mem_req", mem_req, 0);
        chk("rstmid mem_addr", mem_addr, 0);
        chk("rstmid d_ready", d_ready, 0);
        chk("rstmid err_sticky", err_sticky, 0);
        chk("rstmid stall_m", stall_m, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'h3141_5926;
        @(negedge clk);
        chk("rstmid regrant mem_req", mem_req, 1);
        chk("rstmid regrant mem_addr", mem_addr, 32'h400);
        chk("rstmid d_ready", d_ready, 1);
        chk("rstmid d_rdata", d_rdata, 32'h3141_5926);
        @(posedge clk); #1;
        mem_ack = 0; d_req = 0; mem_rdata = 0;
        @(negedge clk);
        chk("rstmid done mem_req", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
